instr_decoder_seq: RTL
======================

# instr_decoder_seq

Clocked, parametrised instruction decoder for the ALU datapath. Accepts one instruction word per valid/ready handshake, splits it into opcode (OPR) and operand (OPA), and issues a registered decode record (mode, register index, accumulator immediate, status) to the ALU over a second valid/ready handshake. Illegal opcodes and out-of-range register indices are trapped and flagged rather than silently ignored. It replaces the level-sensitive 8-bit decoder between instruction fetch and the ALU.

## Interface
- OPR_W, 4, opcode field width; instruction bits [OPR_W+OPA_W-1:OPA_W]
- OPA_W, 4, operand field width; instruction bits [OPA_W-1:0]; also the accumulator width
- IDX_W, 3, register index width; legal indices 0..2^IDX_W-1; must satisfy IDX_W <= OPA_W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  decoder can accept this cycle
- instr  in  OPR_W+OPA_W  instruction word
- out_valid  out  1  decode record valid
- out_ready  in  1  ALU consumes record
- mode  out  3  ALU mode; 0 = load immediate, 1..4 = ALU operation 1..4
- index  out  IDX_W  register index for modes 1..4; 0 for load
- accumulator  out  OPA_W  immediate, last loaded value
- status  out  4  sticky flags: [0] illegal opcode, [1] index out of range, [3:2] reserved 0
- illegal  out  1  one-cycle pulse when a trapped instruction is accepted
- processing  out  1  toggles once per issued record

## Operation
- Opcode map: 1 = LDI (accumulator <= OPA, status <= 0, mode 0); 2,3,4,5 = modes 1,2,3,4 with index <= OPA[IDX_W-1:0]; 0 = NOP (accepted, nothing issued, no flag); all other opcodes illegal.
- Modes 1..4 with OPA >= 2^IDX_W: trapped; status[1] set.
- Illegal opcode: trapped; status[0] set.
- Trapped instructions are accepted (consumed), never issued; illegal pulses high for the cycle after acceptance; mode/index/accumulator hold their previous values.
- status is sticky; cleared only by reset or by an issued LDI. An LDI clears status, then the trap logic may set bits again on later instructions.
- FSM: IDLE (out_valid=0) -> ISSUE on accepted issuable instruction; ISSUE -> IDLE on out_ready with no new issuable acceptance; ISSUE -> ISSUE on out_ready with a simultaneous issuable acceptance (back-to-back).
- instr_ready = !out_valid || out_ready (combinational from out_ready; no path from instr_valid).
- accumulator persists across non-LDI records.

## Timing
- Latency: accepted at edge N -> record on outputs and out_valid high after edge N, i.e. in cycle N+1.
- Throughput: one instruction per cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, all record outputs stable, instr_ready = 0.
- processing toggles on the same edge that loads a new record into ISSUE.
- Reset (asynchronous, any cycle, including mid-stall): state IDLE, out_valid 0, mode 0, index 0, accumulator 0, status 0, illegal 0, processing 0; pending record discarded; instr_ready 1 one cycle after reset deassertion.

## Configuration
- INSTR_DEC_PERF_EN defined: adds outputs issue_count (16 bits, increments per issued record) and trap_count (16 bits, increments per trapped instruction), both saturating at 16'hFFFF, reset to 0, cleared together with status by LDI is NOT done—only reset clears them.
- Not defined: ports and counters absent; all other behaviour identical.

## Structure
- Package instr_dec_pkg: opcode constants (OP_NOP, OP_LDI, OP_M1..OP_M4), mode constants (MODE_LDI, MODE_1..MODE_4), status bit positions, decode record typedef.
- Sub-module instr_dec_core: purely combinational field split, opcode lookup, index range check; produces issue/trap/flag signals. Top holds FSM, record registers, status and counters.

## Test plan
- Reset, then instr 8'h1A with out_ready=1 -> next cycle out_valid=1, mode 0, accumulator 4'hA, status 0, processing 1.
- instr 8'h23, 8'h37, 8'h40, 8'h55 back-to-back, out_ready=1 -> four consecutive records modes 1,2,3,4, indices 3,7,0,5; processing toggles each cycle.
- instr 8'h29 (index 9 > 7) -> no out_valid, illegal pulse 1 cycle, status 4'b0010; then 8'h10 -> status 0.
- instr 8'hF0 -> illegal pulse, status 4'b0001; 8'h00 -> accepted, no record, no flag.
- Hold out_ready=0 after 8'h31 -> record held stable, instr_ready=0 for 5 cycles; raise out_ready with 8'h42 valid -> 8'h42 record next cycle.
- Assert rst_n=0 mid-stall -> all outputs zero immediately; with INSTR_DEC_PERF_EN, issue_count and trap_count read 0.

Source files
------------

// File: rtl/instr_dec_pkg.sv
// instr_dec_pkg: shared constants and types for the sequential instruction decoder.
//   - opcode values (OP_*), ALU mode encodings (MODE_*), status bit positions (ST_*)
//   - dec_t: per-instruction decode record produced by instr_dec_core
//   - state_t: issue FSM states used by instr_decoder_seq
package instr_dec_pkg;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDI = 1;
  localparam int unsigned OP_M1  = 2;
  localparam int unsigned OP_M2  = 3;
  localparam int unsigned OP_M3  = 4;
  localparam int unsigned OP_M4  = 5;

  localparam logic [2:0] MODE_LDI = 3'd0;
  localparam logic [2:0] MODE_1   = 3'd1;
  localparam logic [2:0] MODE_2   = 3'd2;
  localparam logic [2:0] MODE_3   = 3'd3;
  localparam logic [2:0] MODE_4   = 3'd4;

  localparam int unsigned ST_ILL = 0;  // illegal opcode
  localparam int unsigned ST_IDX = 1;  // register index out of range

  typedef struct packed {
    logic       issue;    // instruction produces a record for the ALU
    logic       trap;     // instruction is consumed but flagged
    logic       is_ldi;   // load-immediate record
    logic       ill_op;   // opcode not in the map
    logic       idx_oor;  // operand does not fit in the register index
    logic [2:0] mode;     // ALU mode for an issued record
  } dec_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/instr_dec_core.sv
// instr_dec_core: combinational field split and opcode classification.
//   instr in  : instruction word {OPR, OPA}
//   dec   out : decode record (issue / trap / flags / mode)
//   opa   out : operand field
//   idx   out : low IDX_W bits of the operand (register index)
module instr_dec_core
  import instr_dec_pkg::*;
#(
  parameter int OPR_W = 4,
  parameter int OPA_W = 4,
  parameter int IDX_W = 3
) (
  input  logic [OPR_W+OPA_W-1:0] instr,
  output dec_t                   dec,
  output logic [OPA_W-1:0]       opa,
  output logic [IDX_W-1:0]       idx
);

  localparam logic [OPR_W-1:0] C_NOP = OPR_W'(OP_NOP);
  localparam logic [OPR_W-1:0] C_LDI = OPR_W'(OP_LDI);
  localparam logic [OPR_W-1:0] C_M1  = OPR_W'(OP_M1);
  localparam logic [OPR_W-1:0] C_M2  = OPR_W'(OP_M2);
  localparam logic [OPR_W-1:0] C_M3  = OPR_W'(OP_M3);
  localparam logic [OPR_W-1:0] C_M4  = OPR_W'(OP_M4);

  logic [OPR_W-1:0] opr_s;
  logic             oor_s;
  logic             reg_op_s;
  logic [2:0]       reg_mode_s;

  assign opr_s = instr[OPR_W+OPA_W-1:OPA_W];
  assign opa   = instr[OPA_W-1:0];
  assign idx   = opa[IDX_W-1:0];
  // Any operand bit above the index field means the register does not exist.
  assign oor_s = |(opa >> IDX_W);

  // Opcode lookup: classify into NOP / LDI / register op / illegal.
  always_comb begin
    dec        = '0;
    reg_op_s   = 1'b0;
    reg_mode_s = MODE_LDI;
    case (opr_s)
      C_NOP: begin
        dec.issue = 1'b0;
      end
      C_LDI: begin
        dec.issue  = 1'b1;
        dec.is_ldi = 1'b1;
        dec.mode   = MODE_LDI;
      end
      C_M1: begin
        reg_op_s   = 1'b1;
        reg_mode_s = MODE_1;
      end
      C_M2: begin
        reg_op_s   = 1'b1;
        reg_mode_s = MODE_2;
      end
      C_M3: begin
        reg_op_s   = 1'b1;
        reg_mode_s = MODE_3;
      end
      C_M4: begin
        reg_op_s   = 1'b1;
        reg_mode_s = MODE_4;
      end
      default: begin
        dec.trap   = 1'b1;
        dec.ill_op = 1'b1;
      end
    endcase
    if (reg_op_s) begin
      dec.mode    = reg_mode_s;
      dec.issue   = !oor_s;
      dec.trap    = oor_s;
      dec.idx_oor = oor_s;
    end else begin
      dec.idx_oor = 1'b0;
    end
  end

endmodule

// File: rtl/instr_decoder_seq.sv
// instr_decoder_seq: registered instruction decoder between fetch and the ALU.
//   clk, rst_n              : clock, asynchronous active-low reset
//   instr_valid/instr_ready : instruction handshake; instr = {OPR, OPA}
//   out_valid/out_ready     : decode record handshake towards the ALU
//   mode, index, accumulator: decode record
//   status                  : sticky trap flags [0] illegal opcode, [1] index out of range
//   illegal                 : one-cycle pulse after a trapped instruction is accepted
//   processing              : toggles once per issued record
// Optional: define INSTR_DEC_PERF_EN to add saturating issue_count / trap_count outputs.
module instr_decoder_seq
  import instr_dec_pkg::*;
#(
  parameter int OPR_W = 4,
  parameter int OPA_W = 4,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [OPR_W+OPA_W-1:0] instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             mode,
  output logic [IDX_W-1:0]       index,
  output logic [OPA_W-1:0]       accumulator,
  output logic [3:0]             status,
  output logic                   illegal,
  output logic                   processing
`ifdef INSTR_DEC_PERF_EN
  ,
  output logic [15:0]            issue_count,
  output logic [15:0]            trap_count
`endif
);

  dec_t             dec_s;
  logic [OPA_W-1:0] opa_s;
  logic [IDX_W-1:0] idx_s;
  logic             accept_s;
  logic             issue_acc_s;
  logic             trap_acc_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic [2:0]       mode_r;
  logic [IDX_W-1:0] index_r;
  logic [OPA_W-1:0] acc_r;
  logic [3:0]       status_r;
  logic             illegal_r;
  logic             proc_r;

  instr_dec_core #(
    .OPR_W(OPR_W),
    .OPA_W(OPA_W),
    .IDX_W(IDX_W)
  ) u_core (
    .instr(instr),
    .dec  (dec_s),
    .opa  (opa_s),
    .idx  (idx_s)
  );

  assign out_valid   = (state_r == S_ISSUE);
  assign instr_ready = !out_valid || out_ready;
  assign accept_s    = instr_valid && instr_ready;
  assign issue_acc_s = accept_s && dec_s.issue;
  assign trap_acc_s  = accept_s && dec_s.trap;

  assign mode        = mode_r;
  assign index       = index_r;
  assign accumulator = acc_r;
  assign status      = status_r;
  assign illegal     = illegal_r;
  assign processing  = proc_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: a new issuable acceptance always lands in ISSUE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (issue_acc_s) begin
          state_nx_s = S_ISSUE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (out_ready && !issue_acc_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_ISSUE;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Record, sticky status and trap pulse; trapped words leave the record untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= 3'd0;
      index_r   <= '0;
      acc_r     <= '0;
      status_r  <= 4'd0;
      illegal_r <= 1'b0;
      proc_r    <= 1'b0;
    end else begin
      illegal_r <= trap_acc_s;
      if (issue_acc_s) begin
        mode_r <= dec_s.mode;
        proc_r <= !proc_r;
        if (dec_s.is_ldi) begin
          index_r  <= '0;
          acc_r    <= opa_s;
          status_r <= 4'd0;
        end else begin
          index_r <= idx_s;
        end
      end else if (trap_acc_s) begin
        if (dec_s.ill_op) begin
          status_r[ST_ILL] <= 1'b1;
        end
        if (dec_s.idx_oor) begin
          status_r[ST_IDX] <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_DEC_PERF_EN
  logic [15:0] issue_cnt_r;
  logic [15:0] trap_cnt_r;

  assign issue_count = issue_cnt_r;
  assign trap_count  = trap_cnt_r;

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= 16'd0;
      trap_cnt_r  <= 16'd0;
    end else begin
      if (issue_acc_s && (issue_cnt_r != 16'hFFFF)) begin
        issue_cnt_r <= issue_cnt_r + 16'd1;
      end
      if (trap_acc_s && (trap_cnt_r != 16'hFFFF)) begin
        trap_cnt_r <= trap_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule
